// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: packet-level 1-to-2 valid/ready stream demultiplexer.
//
// The destination of each packet is sampled from in_sel on the packet's first
// beat and then held until the packet's last beat. Every output has its own
// one-entry register stage, so a stalled consumer only blocks packets that are
// headed to that consumer.
//
// A packet that reaches MAX_BEATS beats without in_last is cut short. Its
// MAX_BEATS-th beat is sent out with last=1, the sticky pkt_err flag is set,
// and the beat after it starts a new packet.
//
// Optional feature: define DEMUX_STATS_EN to add pkt_cnt0/pkt_cnt1. These are
// wrapping 16-bit counters of packets delivered on each output.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready          input handshake (in_ready is combinational)
//   in_data, in_sel, in_last   input payload, destination, end of packet
//   outN_valid/outN_ready      output handshakes, N = 0,1
//   outN_data, outN_last       registered output payload and last flag
//   pkt_cnt0, pkt_cnt1         delivered packet counts (DEMUX_STATS_EN only)
//   pkt_err                    sticky forced-termination flag
module demux_1x2_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
`ifdef DEMUX_STATS_EN
  output logic [15:0]      pkt_cnt0,
  output logic [15:0]      pkt_cnt1,
`endif
  output logic             pkt_err
);

  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          lock_sel_q, lock_sel_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic          cur_sel_c;
  logic [CW-1:0] beat_num_c;
  logic          accept_c;
  logic          at_max_c;
  logic          eff_last_c;
  logic          forced_c;
  logic          load0_c;
  logic          load1_c;

  // State register: FSM state, the locked destination and the beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic. A single-beat packet leaves the FSM in IDLE.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    beat_cnt_d = beat_cnt_q;
    if (accept_c) begin
      case (state_q)
        ST_IDLE: begin
          lock_sel_d = in_sel;
          if (!in_last) begin
            state_d    = ST_BUSY;
            beat_cnt_d = CW'(1);
          end
        end
        ST_BUSY: begin
          if (eff_last_c) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_num_c;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output/steering logic. beat_num_c is the 1-based index of the beat being
  // offered now. in_ready depends only on the chosen output register and its
  // consumer, never on in_valid.
  always_comb begin
    cur_sel_c  = (state_q == ST_IDLE) ? in_sel : lock_sel_q;
    beat_num_c = (state_q == ST_IDLE) ? CW'(1) : CW'(beat_cnt_q + CW'(1));
    in_ready   = cur_sel_c ? (~out1_valid | out1_ready)
                           : (~out0_valid | out0_ready);
    accept_c   = in_valid & in_ready;
    at_max_c   = (beat_num_c == CW'(MAX_BEATS));
    eff_last_c = in_last | at_max_c;
    forced_c   = accept_c & at_max_c & ~in_last;
    load0_c    = accept_c & ~cur_sel_c;
    load1_c    = accept_c & cur_sel_c;
  end

  // Output 0 register stage. A load in the same cycle as a drain takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
      out0_last  <= 1'b0;
    end else if (load0_c) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
      out0_last  <= eff_last_c;
    end else if (out0_valid && out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  // Output 1 register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
      out1_last  <= 1'b0;
    end else if (load1_c) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
      out1_last  <= eff_last_c;
    end else if (out1_valid && out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

  // Sticky forced-termination flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_err <= 1'b0;
    end else if (forced_c) begin
      pkt_err <= 1'b1;
    end
  end

`ifdef DEMUX_STATS_EN
  // Delivered-packet counters. They wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready && out0_last) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (out1_valid && out1_ready && out1_last) pkt_cnt1 <= pkt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Testbench for demux_1x2_stream. A packet-level reference model predicts the
// contents of each one-deep output stage (kept as a queue), the sticky error
// flag and the delivered-packet counts. Every cycle the bench compares these
// predictions with the DUT outputs.
module tb_demux_1x2_stream;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BEATS = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_sel, in_last;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out0_ready, out0_last;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid, out1_ready, out1_last;
  logic [WIDTH-1:0] out1_data;
  logic             pkt_err;
`ifdef DEMUX_STATS_EN
  logic [15:0]      pkt_cnt0, pkt_cnt1;
`endif

  demux_1x2_stream #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
`ifdef DEMUX_STATS_EN
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1),
`endif
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state. Each queue entry holds {last, data}.
  logic [WIDTH:0] q0[$];
  logic [WIDTH:0] q1[$];
  bit             m_in_pkt;
  bit             m_sel;
  int             m_beats;
  bit             m_err;
  logic [15:0]    m_cnt0, m_cnt1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_in_pkt = 1'b0;
    m_sel    = 1'b0;
    m_beats  = 0;
    m_err    = 1'b0;
    m_cnt0   = '0;
    m_cnt1   = '0;
  endtask

  // Drive one cycle of stimulus, compare the DUT with the model, then advance the model.
  task automatic step(input logic v, input logic s, input logic l,
                      input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    logic exp_rdy;
    logic sel;
    int   bn;
    logic lx;
    @(negedge clk);
    in_valid = v; in_sel = s; in_last = l; in_data = d;
    out0_ready = r0; out1_ready = r1;
    #1;
    sel     = m_in_pkt ? m_sel : s;
    exp_rdy = sel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_eq("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    check_eq("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) check_eq("out0_beat", 32'({out0_last, out0_data}), 32'(q0[0]));
    if (q1.size() != 0) check_eq("out1_beat", 32'({out1_last, out1_data}), 32'(q1[0]));
    check_eq("pkt_err", 32'(pkt_err), 32'(m_err));
`ifdef DEMUX_STATS_EN
    check_eq("pkt_cnt0", 32'(pkt_cnt0), 32'(m_cnt0));
    check_eq("pkt_cnt1", 32'(pkt_cnt1), 32'(m_cnt1));
`endif
    if (q0.size() != 0 && r0) begin
      if (q0[0][WIDTH]) m_cnt0 = m_cnt0 + 16'd1;
      void'(q0.pop_front());
    end
    if (q1.size() != 0 && r1) begin
      if (q1[0][WIDTH]) m_cnt1 = m_cnt1 + 16'd1;
      void'(q1.pop_front());
    end
    if (v && exp_rdy) begin
      bn = m_in_pkt ? m_beats + 1 : 1;
      lx = l || (bn == int'(MAX_BEATS));
      if (!l && bn == int'(MAX_BEATS)) m_err = 1'b1;
      if (sel) q1.push_back({lx, d});
      else     q0.push_back({lx, d});
      if (lx) begin
        m_in_pkt = 1'b0;
        m_beats  = 0;
      end else begin
        m_in_pkt = 1'b1;
        m_beats  = bn;
        m_sel    = sel;
      end
    end
  endtask

  // Apply reset for one cycle and check the outputs go to zero immediately.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("rst_out0_valid", 32'(out0_valid), 32'd0);
    check_eq("rst_out1_valid", 32'(out1_valid), 32'd0);
    check_eq("rst_out0_beat", 32'({out0_last, out0_data}), 32'd0);
    check_eq("rst_out1_beat", 32'({out1_last, out1_data}), 32'd0);
    check_eq("rst_pkt_err", 32'(pkt_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_sel = 1'b0; in_last = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // 3-beat packet to out1
    step(1'b1, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b1);
    drain();

    // in_sel toggles mid-packet; the packet stays locked to out0
    step(1'b1, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'hB3, 1'b1, 1'b1);
    drain();

    // out0 stalled holding 0x55; 0x66 still passes through out1
    step(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    drain();

    // 17 beats with no last: beat 16 is forced last, beat 17 starts a new packet
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    drain();
    check_eq("pkt_err_sticky", 32'(pkt_err), 32'd1);

    // Reset during beat 2 of a packet on out1
    step(1'b1, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'hC9, 1'b1, 1'b1);
    drain();

    // Random traffic, normal packet lengths
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) < 2,
           8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    // Random traffic, long packets that often hit forced termination
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 29) == 0,
           8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    drain();

`ifdef DEMUX_STATS_EN
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h04, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b1);
    drain();
    check_eq("stats_cnt0", 32'(pkt_cnt0), 32'd3);
    check_eq("stats_cnt1", 32'(pkt_cnt1), 32'd2);
    do_reset();
    for (int i = 0; i < 65536; i++) step(1'b1, 1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
    drain();
    check_eq("stats_wrap", 32'(pkt_cnt1), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
